// File: rtl/dpram_rd_streamer.sv
// dpram_rd_streamer: streams a contiguous RAM address window out as a
// valid/ready byte stream, pipelined against the RAM read latency, with a
// small skid FIFO sized so that backpressure never loses or repeats a word.
// Optional build macro: DPR_RD_CHECKSUM_EN (XOR checksum of streamed data).
module dpram_rd_streamer #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   burst_len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_enb,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [DATA_W-1:0] checksum
);

    localparam int unsigned FIFO_D = RD_LAT + 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_D + 1);
    localparam int unsigned PTR_W  = $clog2(FIFO_D);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state;
    logic [ADDR_W:0]     remaining;
    logic [RD_LAT-1:0]   vld_sr;
    logic [RD_LAT-1:0]   last_sr;
    logic [DATA_W-1:0]   fifo_data [FIFO_D];
    logic                fifo_last [FIFO_D];
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [CNT_W-1:0]    fifo_count;

    logic                accept_c;
    logic                issue_c;
    logic                push_c;
    logic                pop_c;
    logic [CNT_W-1:0]    in_flight_c;
    logic [CNT_W-1:0]    in_flight_nxt_c;
    logic [CNT_W-1:0]    fifo_count_nxt_c;
    logic [CNT_W:0]      occupancy_c;
    logic [PTR_W-1:0]    rd_ptr_nxt_c;
    logic [PTR_W-1:0]    wr_ptr_nxt_c;
    logic [RD_LAT-1:0]   vld_sr_nxt_c;
    logic [RD_LAT-1:0]   last_sr_nxt_c;
    logic [DATA_W-1:0]   head_data_c;
    logic                head_last_c;

    // This port only ever reads.
    assign mem_wr_enb = 1'b0;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_D - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credit, read pipeline and skid-FIFO next-state computation.
    always_comb begin
        accept_c         = 1'b0;
        issue_c          = 1'b0;
        push_c           = 1'b0;
        pop_c            = 1'b0;
        in_flight_c      = '0;
        in_flight_nxt_c  = '0;
        fifo_count_nxt_c = fifo_count;
        occupancy_c      = '0;
        rd_ptr_nxt_c     = rd_ptr;
        wr_ptr_nxt_c     = wr_ptr;
        vld_sr_nxt_c     = '0;
        last_sr_nxt_c    = '0;
        head_data_c      = out_data;
        head_last_c      = 1'b0;

        // done high means a burst just closed; holding off keeps done and
        // start acceptance out of the same cycle.
        accept_c = (state == IDLE) && start && !done;
        push_c   = vld_sr[RD_LAT-1];
        pop_c    = out_valid && out_ready;

        for (int i = 0; i < int'(RD_LAT); i++) begin
            in_flight_c = in_flight_c + CNT_W'(vld_sr[i]);
        end

        // A word leaving this cycle frees its slot for an issue this cycle.
        occupancy_c = (CNT_W+1)'(in_flight_c) + (CNT_W+1)'(fifo_count) - (CNT_W+1)'(pop_c);
        issue_c     = (state == ISSUE) && (occupancy_c < (CNT_W+1)'(FIFO_D));

        vld_sr_nxt_c[0]  = issue_c;
        last_sr_nxt_c[0] = issue_c && (remaining == (ADDR_W+1)'(1));
        for (int i = 1; i < int'(RD_LAT); i++) begin
            vld_sr_nxt_c[i]  = vld_sr[i-1];
            last_sr_nxt_c[i] = last_sr[i-1];
        end

        in_flight_nxt_c  = in_flight_c - CNT_W'(push_c) + CNT_W'(issue_c);
        fifo_count_nxt_c = fifo_count + CNT_W'(push_c) - CNT_W'(pop_c);
        rd_ptr_nxt_c     = pop_c  ? ptr_inc(rd_ptr) : rd_ptr;
        wr_ptr_nxt_c     = push_c ? ptr_inc(wr_ptr) : wr_ptr;

        // Next head: bypass the incoming word when the FIFO would otherwise be empty.
        if (fifo_count_nxt_c != '0) begin
            if (fifo_count == CNT_W'(pop_c)) begin
                head_data_c = mem_rdata;
                head_last_c = last_sr[RD_LAT-1];
            end else begin
                head_data_c = fifo_data[rd_ptr_nxt_c];
                head_last_c = fifo_last[rd_ptr_nxt_c];
            end
        end
    end

    // Burst FSM, address generator, read pipeline tags and registered stream outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            remaining  <= '0;
            mem_addr   <= '0;
            vld_sr     <= '0;
            last_sr    <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
        end else begin
            done       <= 1'b0;
            vld_sr     <= vld_sr_nxt_c;
            last_sr    <= last_sr_nxt_c;
            rd_ptr     <= rd_ptr_nxt_c;
            wr_ptr     <= wr_ptr_nxt_c;
            fifo_count <= fifo_count_nxt_c;
            out_valid  <= (fifo_count_nxt_c != '0);
            out_data   <= head_data_c;
            out_last   <= head_last_c;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        if (burst_len != '0) begin
                            state     <= ISSUE;
                            busy      <= 1'b1;
                            remaining <= burst_len;
                            mem_addr  <= base_addr;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (issue_c) begin
                        remaining <= remaining - (ADDR_W+1)'(1);
                        mem_addr  <= mem_addr + ADDR_W'(1);
                        if (remaining == (ADDR_W+1)'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if ((fifo_count_nxt_c == '0) && (in_flight_nxt_c == '0)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Skid FIFO storage; contents are meaningless until counted in.
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_data[wr_ptr] <= mem_rdata;
            fifo_last[wr_ptr] <= last_sr[RD_LAT-1];
        end
    end

`ifdef DPR_RD_CHECKSUM_EN
    // XOR of every word actually handed off since the last accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (accept_c) begin
            checksum <= '0;
        end else if (pop_c) begin
            checksum <= checksum ^ out_data;
        end
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_dpram_rd_streamer.sv
// Bench for dpram_rd_streamer: behavioural RAM, scoreboard of expected words
// filled when each burst is launched, compared at every stream handshake.
`timescale 1ns/1ps
module tb_dpram_rd_streamer;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned RD_LAT = 1;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   burst_len;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr_enb;
    logic [DATA_W-1:0] mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic [DATA_W-1:0] checksum;

    dpram_rd_streamer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .burst_len(burst_len), .busy(busy), .done(done), .mem_addr(mem_addr),
        .mem_wr_enb(mem_wr_enb), .mem_rdata(mem_rdata), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .checksum(checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM with registered read of RD_LAT clocks.
    logic [DATA_W-1:0] ram     [DEPTH];
    logic [DATA_W-1:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        rd_pipe[0] <= ram[mem_addr];
        for (int i = 1; i < int'(RD_LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RD_LAT-1];

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Sink ready pattern: mode 0 always ready, mode 1 repeats 1,0,0,1.
    int ready_mode = 0;
    int rpat       = 0;
    always @(posedge clk) begin
        #1;
        if (ready_mode == 1) begin
            out_ready = ((rpat % 4) == 0) || ((rpat % 4) == 3);
            rpat++;
        end else begin
            out_ready = 1'b1;
        end
    end

    // Stream monitor: scoreboard, stall stability, issue lead, done count.
    int                hs_cnt   = 0;
    int                done_cnt = 0;
    bit                lead_en  = 0;
    logic [ADDR_W-1:0] cur_base = '0;
    logic              prev_valid = 1'b0;
    logic              prev_ready = 1'b0;
    logic [DATA_W-1:0] prev_data  = '0;
    exp_t              mon_e;
    int                lead;
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_valid && !prev_ready) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(prev_data));
            end
            if (lead_en) begin
                lead = int'(ADDR_W'(mem_addr - cur_base));
                check("issue_lead", 32'(lead <= hs_cnt + int'(RD_LAT) + 1), 32'd1);
            end
            if (out_valid && out_ready) begin
                check("sb_avail", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("data", 32'(out_data), 32'(mon_e.data));
                    check("last", 32'(out_last), 32'(mon_e.last));
                end
                hs_cnt++;
            end
            if (done) done_cnt++;
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_data  = out_data;
        end else begin
            prev_valid = 1'b0;
        end
    end

    logic [ADDR_W-1:0] ma0, ma1;
    int first_k, last_k, done_k;

    // Launch one burst, push its expected words, and follow it to done.
    task automatic run_burst(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len,
                             input int inject_k, input bit lead);
        logic [DATA_W-1:0] x;
        int k;
        exp_t e;
        x = '0;
        for (int i = 0; i < int'(len); i++) begin
            e.data = ram[ADDR_W'(int'(base) + i)];
            e.last = (i == int'(len) - 1);
            sb.push_back(e);
            x ^= e.data;
        end
        hs_cnt = 0; cur_base = base;
        first_k = -1; last_k = -1; done_k = -1;
        @(negedge clk);
        start = 1'b1; base_addr = base; burst_len = len;
        @(negedge clk);
        start = 1'b0;
        lead_en = lead;
        check("busy_on_accept", 32'(busy), 32'd1);
        k = 0;
        while (done_k < 0 && k < 400) begin
            if (k == 0) ma0 = mem_addr;
            if (k == 1) ma1 = mem_addr;
            if (out_valid && first_k < 0) first_k = k;
            if (out_valid && out_ready && out_last) last_k = k;
            if (done) done_k = k;
            if (k == inject_k) begin
                start = 1'b1; base_addr = 6; burst_len = 3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        lead_en = 0;
        check("done_seen", 32'(done_k >= 0), 32'd1);
        check("latency", 32'(first_k), 32'(RD_LAT + 1));
        check("done_after_last", 32'(done_k), 32'(last_k + 1));
        check("word_count", 32'(hs_cnt), 32'(len));
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
`ifdef DPR_RD_CHECKSUM_EN
        check("checksum", 32'(checksum), 32'(x));
`else
        check("checksum", 32'(checksum), 32'd0);
`endif
    endtask

    int d0;
    bit vseen;

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; burst_len = '0; out_ready = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) ram[i] = DATA_W'(8'h40 + i);
        ram[2] = 8'hAA; ram[3] = 8'hEE; ram[4] = 8'hCC; ram[5] = 8'hDD;
        ram[15] = 8'h11; ram[0] = 8'h22;

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_checksum", 32'(checksum), 32'd0);
        check("wr_enb", 32'(mem_wr_enb), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic burst, sink always ready.
        run_burst(4'd2, 5'd4, -1, 1'b0);
        check("throughput", 32'(last_k - first_k), 32'd3);

        // Same burst with backpressure.
        rpat = 0; ready_mode = 1;
        run_burst(4'd2, 5'd4, -1, 1'b1);
        ready_mode = 0;
        repeat (2) @(negedge clk);

        // Wrap from top address to 0.
        run_burst(4'd15, 5'd2, -1, 1'b0);
        check("wrap_addr0", 32'(ma0), 32'hF);
        check("wrap_addr1", 32'(ma1), 32'h0);

        // Zero-length start.
        d0 = done_cnt; vseen = 0;
        @(negedge clk);
        start = 1'b1; base_addr = 4'd5; burst_len = '0;
        @(negedge clk);
        start = 1'b0;
        check("len0_done", 32'(done), 32'd1);
        check("len0_busy", 32'(busy), 32'd0);
        repeat (5) begin
            @(negedge clk);
            vseen |= out_valid;
        end
        check("len0_no_valid", 32'(vseen), 32'd0);
        check("len0_done_once", 32'(done_cnt - d0), 32'd1);
        check("len0_checksum", 32'(checksum), 32'd0);

        // Full-depth burst.
        run_burst(4'd0, 5'd16, -1, 1'b0);
        check("full_throughput", 32'(last_k - first_k), 32'd15);

        // Start pulse mid-burst is ignored.
        run_burst(4'd2, 5'd4, 3, 1'b0);
        repeat (4) @(negedge clk);
        check("inject_idle", 32'(busy), 32'd0);
        check("inject_no_extra", 32'(sb.size()), 32'd0);

        // Reset mid-burst after two words.
        for (int i = 0; i < 4; i++) begin
            mon_e.data = ram[2 + i]; mon_e.last = (i == 3); sb.push_back(mon_e);
        end
        hs_cnt = 0;
        @(negedge clk);
        start = 1'b1; base_addr = 4'd2; burst_len = 5'd4;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 50 && hs_cnt < 2; t++) @(negedge clk);
        check("rst_wait", 32'(hs_cnt >= 2), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_last", 32'(out_last), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'd0);
        check("mid_rst_addr", 32'(mem_addr), 32'd0);
        check("mid_rst_checksum", 32'(checksum), 32'd0);
        d0 = done_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
        check("mid_rst_idle_valid", 32'(out_valid), 32'd0);
        run_burst(4'd3, 5'd3, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/dpram_rd_streamer.md
Name: dpram_rd_streamer

Overview:
- Read-side engine for the dual-port RAM: owns one RAM port and streams a contiguous address window out as a valid/ready byte stream.
- A single start pulse launches a burst.
- Reads are pipelined against the RAM's registered read latency.
- A small internal skid FIFO absorbs backpressure, so no read data is lost or duplicated.

Parameters:
- ADDR_W, 4, RAM address width; depth = 2**ADDR_W.
- DATA_W, 8, RAM data width.
- RD_LAT, 1, RAM read latency in clocks (address to mem_rdata valid); legal range 1..3.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; launches a burst when idle
- base_addr  input  ADDR_W  first address of burst, sampled on accepted start
- burst_len  input  ADDR_W+1  words to read, sampled on accepted start; 0..2**ADDR_W
- busy  output  1  high from accepted start until the last word has been handed off
- done  output  1  one-cycle pulse on the cycle after the last handshake
- mem_addr  output  ADDR_W  RAM port address
- mem_wr_enb  output  1  RAM port write enable; constant 0
- mem_rdata  input  DATA_W  RAM port read data
- out_valid  output  1  stream data valid
- out_ready  input  1  stream sink ready
- out_data  output  DATA_W  stream data
- out_last  output  1  marks the final word of the burst
- checksum  output  DATA_W  see Optional Feature

Behaviour:
- Reset (async, rst_n=0): state IDLE, busy=0, done=0, out_valid=0, out_last=0, out_data=0, mem_addr=0, checksum=0; FIFO emptied; in-flight counters cleared. Reset mid-burst aborts it silently with no done pulse.
- FSM states:
  - IDLE -> ISSUE on start with burst_len!=0.
  - IDLE with start and burst_len==0: stay IDLE, pulse done next cycle, busy stays 0.
  - ISSUE -> DRAIN when the last address has been issued.
  - DRAIN -> IDLE when the FIFO is empty and nothing is in flight; done pulses that cycle.
  - start while busy is ignored.
- Issue and address rules:
  - In ISSUE, one address per cycle when credit allows.
  - mem_addr increments modulo 2**ADDR_W, so a burst wraps from the top address to 0.
  - Remaining count decrements per issue.
- Credit:
  - Skid FIFO depth = RD_LAT+1.
  - Issue is allowed only when (in_flight + fifo_count) < RD_LAT+1, so the FIFO can never overflow.
  - in_flight is tracked with an RD_LAT-deep valid shift register; mem_rdata is captured into the FIFO when the tail bit is set.
- Stream output:
  - out_data/out_valid come from the FIFO head.
  - A handshake occurs when out_valid && out_ready.
  - out_data is held stable while out_valid=1 and out_ready=0.
  - out_last=1 only with the final word's out_valid.
- Throughput: with out_ready held at 1, one word per clock after an initial latency of RD_LAT+1 clocks from start to the first out_valid.
- Simultaneous events: a FIFO push and pop in the same cycle keep the count unchanged. done is never asserted in the same cycle as start acceptance.
- mem_wr_enb is tied 0; this block never writes.

Optional Feature:
- Macro DPR_RD_CHECKSUM_EN.
- Defined: checksum is cleared on accepted start and XOR-accumulates every handshaken out_data. It is stable and final from the done pulse until the next accepted start; it is unaffected by stalls.
- Undefined: checksum is driven constant 0 and no accumulator logic is present.

Test Plan:
- RAM preloaded 2=AA, 3=EE, 4=CC, 5=DD; start base=2, len=4, out_ready=1 -> AA, EE, CC, DD on consecutive clocks; out_last with DD; done one clock later; checksum (if enabled) = AA^EE^CC^DD = 55.
- Same burst with out_ready toggling 1,0,0,1,... -> identical data order, no drops or duplicates, out_data stable while stalled; mem_addr never more than RD_LAT+1 words ahead of the consumer.
- Wrap: RAM F=11, 0=22; base=F, len=2 -> 11 then 22 with out_last on 22; mem_addr sequence F, 0.
- len=0 -> done pulse, busy stays 0, out_valid never asserted. len=16, base=0 -> exactly 16 words, last = RAM[F].
- start pulse mid-burst with base=6 -> ignored, original burst completes unchanged.
- rst_n low mid-burst (after 2 words) -> all outputs 0 immediately; no done pulse; a fresh start after release runs normally.
